// File: rtl/can_tx_bus_scheduler_pkg.sv
// can_tx_bus_scheduler_pkg
//   Shared definitions for the CAN TX bus scheduler slice: bus count, select
//   width and the scheduler FSM state encoding.
//   No ports; imported by can_tx_bus_scheduler and rr_pick32.
package can_tx_bus_scheduler_pkg;

    localparam int N_BUS = 32;
    localparam int SEL_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GUARD  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/can_tx_bus_scheduler_rr_pick32.sv
// rr_pick32
//   Combinational round-robin finder over 32 request lines. Returns the first
//   requesting bus found when searching ptr+1, ptr+2, ... with wrap 31 -> 0.
//   Ports:
//     req  in  32  request vector
//     ptr  in  5   last served bus (search starts just above it)
//     idx  out 5   winning bus index (0 when no request)
//     any  out 1   at least one request is set
module rr_pick32
    import can_tx_bus_scheduler_pkg::*;
(
    input  logic [N_BUS-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [N_BUS-1:0]   upper_mask;
    logic [2*N_BUS-1:0] dbl_req;

    // Keep only the requests strictly above ptr in the low half.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N_BUS; i++) begin
            upper_mask[i] = (i > int'(ptr));
        end
    end

    // Low half = masked requests (searched first), high half = all requests
    // (the wrapped search). The lowest set bit of the 64-bit vector is the
    // winner; its index modulo 32 is the bus number.
    assign dbl_req = {req, req & upper_mask};

    always_comb begin
        idx = '0;
        for (int i = 2*N_BUS-1; i >= 0; i--) begin
            if (dbl_req[i]) begin
                idx = i[SEL_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/can_tx_bus_scheduler.sv
// can_tx_bus_scheduler
//   Shares the single serial CAN TX path among 32 buses. Picks a requesting
//   bus round-robin, holds the demux select for a whole frame, then waits for
//   a recessive guard gap on tx_bit before arbitrating again.
//   Ports:
//     clk          in   1   system clock
//     rst          in   1   synchronous reset, active-low
//     req          in   32  per-bus TX request (level)
//     done         in   1   frame finished pulse from the CAN core
//     tx_bit       in   1   serial TX bit (1 = recessive)
//     sel          out  5   demux select
//     gnt          out  32  one-hot grant (zero when nothing granted)
//     busy         out  1   scheduler is not idle
//     timeout_err  out  1   pulse when a HOLD is aborted by the timeout
module can_tx_bus_scheduler
    import can_tx_bus_scheduler_pkg::*;
#(
    parameter int GUARD_CYC   = 8,
    parameter int TIMEOUT_CYC = 50000
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BUS-1:0] req,
    input  logic             done,
    input  logic             tx_bit,
    output logic [SEL_W-1:0] sel,
    output logic [N_BUS-1:0] gnt,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CNT_MAX = (TIMEOUT_CYC > GUARD_CYC) ? TIMEOUT_CYC : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    sched_state_e     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_BUS-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick32 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // State and output registers. ptr resets to the last bus so the first
    // search after reset begins at bus 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            ptr_q         <= '1;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            hold_cnt_q    <= '0;
            guard_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            hold_cnt_q    <= hold_cnt_d;
            guard_cnt_q   <= guard_cnt_d;
        end
    end

    // Next-state logic. sel only moves on the IDLE->SETTLE transition; the
    // grant appears one cycle later so the demux path has settled.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        timeout_err_d = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        guard_cnt_d   = guard_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d    = ST_HOLD;
                gnt_d      = N_BUS'(1) << sel_q;
                hold_cnt_d = '0;
            end
            ST_HOLD: begin
                // A normal finish or requester abort takes priority over an
                // expiry in the same cycle, so no error is flagged then.
                if (done || !req[sel_q]) begin
                    state_d     = ST_GUARD;
                    gnt_d       = '0;
                    guard_cnt_d = '0;
                end else if ((TIMEOUT_CYC != 0) && (hold_cnt_q == TIMEOUT_LAST)) begin
                    state_d       = ST_GUARD;
                    gnt_d         = '0;
                    guard_cnt_d   = '0;
                    timeout_err_d = 1'b1;
                end else if (hold_cnt_q != CNT_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_GUARD: begin
                // Count consecutive recessive bits; any dominant bit restarts
                // the gap.
                if (!tx_bit) begin
                    guard_cnt_d = '0;
                end else if (guard_cnt_q == GUARD_LAST) begin
                    guard_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign sel         = sel_q;
    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_can_tx_bus_scheduler.sv
// tb_can_tx_bus_scheduler
//   Directed self-checking bench for can_tx_bus_scheduler. Inputs are driven
//   1 time unit after each rising edge and outputs are checked there too.
module tb_can_tx_bus_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic        tx_bit;
    logic [4:0]  sel;
    logic [31:0] gnt;
    logic        busy;
    logic        timeout_err;

    int n_tests;
    int n_failed;

    can_tx_bus_scheduler #(
        .GUARD_CYC   (8),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .tx_bit      (tx_bit),
        .sel         (sel),
        .gnt         (gnt),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        req    = '0;
        done   = 1'b0;
        tx_bit = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    // Waits (bounded) for any grant; the caller compares what arrived.
    task automatic wait_gnt(input int budget);
        for (int c = 0; c < budget && gnt == '0; c++) begin
            step(1);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && busy; c++) begin
            step(1);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        done   = 1'b0;
        tx_bit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = $urandom;
            step(1);
        end
        n_tests++;
        if (sel !== 5'd0) begin n_failed++; $display("[TB] FAIL reset_sel got %0d want 0", sel); end
        n_tests++;
        if (gnt !== 32'h0) begin n_failed++; $display("[TB] FAIL reset_gnt got %h want 0", gnt); end
        n_tests++;
        if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_tests++;
        if (timeout_err !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_terr got %b want 0", timeout_err); end
        req = '0;
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_latency();
        do_reset();
        req = 32'h0000_0001;
        step(1);
        n_tests++;
        if (sel !== 5'd0 || gnt !== 32'h0 || busy !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL lat_c1 got sel=%0d gnt=%h busy=%b want sel=0 gnt=0 busy=1", sel, gnt, busy);
        end
        step(1);
        n_tests++;
        if (gnt !== 32'h1) begin n_failed++; $display("[TB] FAIL lat_c2 got gnt=%h want 1", gnt); end
        step(8);
        n_tests++;
        if (gnt !== 32'h1) begin n_failed++; $display("[TB] FAIL lat_c10 got gnt=%h want 1", gnt); end
        done = 1'b1;
        req  = '0;
        step(1);
        done = 1'b0;
        n_tests++;
        if (gnt !== 32'h0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL lat_c11 got gnt=%h busy=%b terr=%b want gnt=0 busy=1 terr=0", gnt, busy, timeout_err);
        end
        step(7);
        n_tests++;
        if (busy !== 1'b1) begin n_failed++; $display("[TB] FAIL lat_guard7 got busy=%b want 1", busy); end
        step(1);
        n_tests++;
        if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL lat_guard8 got busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [4:0] order [5];
        order = '{5'd0, 5'd2, 5'd31, 5'd0, 5'd2};
        do_reset();
        req = 32'h8000_0005;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(40);
            n_tests++;
            if (gnt !== (32'h1 << order[g]) || sel !== order[g]) begin
                n_failed++;
                $display("[TB] FAIL rr_grant%0d got sel=%0d gnt=%h want sel=%0d", g, sel, gnt, order[g]);
            end
            done = 1'b1;
            step(1);
            done = 1'b0;
        end
        req = '0;
        wait_idle(40);
    endtask

    task automatic test_timeout();
        int pulses;
        int pulse_at;
        logic [31:0] gnt_at_pulse;
        do_reset();
        req = 32'h1 << 7;
        wait_gnt(10);
        n_tests++;
        if (gnt !== (32'h1 << 7)) begin n_failed++; $display("[TB] FAIL to_grant got gnt=%h want 00000080", gnt); end
        pulses       = 0;
        pulse_at     = -1;
        gnt_at_pulse = 32'hFFFF_FFFF;
        for (int c = 1; c <= 25; c++) begin
            step(1);
            if (timeout_err) begin
                pulses++;
                if (pulse_at < 0) begin
                    pulse_at     = c;
                    gnt_at_pulse = gnt;
                end
            end
        end
        n_tests++;
        if (pulses !== 1) begin n_failed++; $display("[TB] FAIL to_pulses got %0d want 1", pulses); end
        n_tests++;
        if (pulse_at !== 20) begin n_failed++; $display("[TB] FAIL to_pulse_cycle got %0d want 20", pulse_at); end
        n_tests++;
        if (gnt_at_pulse !== 32'h0) begin n_failed++; $display("[TB] FAIL to_gnt_at_pulse got %h want 0", gnt_at_pulse); end

        // re-grant after the guard gap, then finish exactly at expiry
        wait_gnt(20);
        n_tests++;
        if (gnt !== (32'h1 << 7)) begin n_failed++; $display("[TB] FAIL to_regrant got gnt=%h want 00000080", gnt); end
        step(19);
        done = 1'b1;
        step(1);
        done = 1'b0;
        n_tests++;
        if (timeout_err !== 1'b0 || gnt !== 32'h0) begin
            n_failed++;
            $display("[TB] FAIL to_done_wins got terr=%b gnt=%h want terr=0 gnt=0", timeout_err, gnt);
        end
        step(1);
        n_tests++;
        if (timeout_err !== 1'b0) begin n_failed++; $display("[TB] FAIL to_done_wins_late got terr=%b want 0", timeout_err); end
        req = '0;
        wait_idle(40);
    endtask

    task automatic test_guard();
        logic sel_moved;
        logic [3:0] pat;
        pat = 4'b0111;
        do_reset();
        req = 32'h1 << 12;
        wait_gnt(10);
        done = 1'b1;
        req  = '0;
        step(1);
        done = 1'b0;
        n_tests++;
        if (gnt !== 32'h0 || busy !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL guard_entry got gnt=%h busy=%b want gnt=0 busy=1", gnt, busy);
        end
        sel_moved = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tx_bit = pat[k];
            step(1);
            if (sel !== 5'd12) sel_moved = 1'b1;
        end
        tx_bit = 1'b1;
        step(7);
        if (sel !== 5'd12) sel_moved = 1'b1;
        n_tests++;
        if (busy !== 1'b1) begin n_failed++; $display("[TB] FAIL guard_ones7 got busy=%b want 1", busy); end
        step(1);
        n_tests++;
        if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL guard_ones8 got busy=%b want 0", busy); end
        step(2);
        if (sel !== 5'd12) sel_moved = 1'b1;
        n_tests++;
        if (sel_moved !== 1'b0) begin n_failed++; $display("[TB] FAIL guard_sel_stable got sel=%0d want 12", sel); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 32'h1 << 5;
        wait_gnt(10);
        n_tests++;
        if (gnt !== (32'h1 << 5)) begin n_failed++; $display("[TB] FAIL rmh_grant got gnt=%h want 00000020", gnt); end
        rst = 1'b0;
        step(1);
        n_tests++;
        if (gnt !== 32'h0 || sel !== 5'd0 || busy !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL rmh_cleared got gnt=%h sel=%0d busy=%b want 0 0 0", gnt, sel, busy);
        end
        rst = 1'b1;
        req = (32'h1 << 5) | (32'h1 << 9);
        wait_gnt(10);
        n_tests++;
        if (gnt !== (32'h1 << 5) || sel !== 5'd5) begin
            n_failed++;
            $display("[TB] FAIL rmh_from_bus0 got sel=%0d gnt=%h want sel=5", sel, gnt);
        end
        req = '0;
        done = 1'b1;
        step(1);
        done = 1'b0;
        wait_idle(40);
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst      = 1'b0;
        req      = '0;
        done     = 1'b0;
        tx_bit   = 1'b1;
        step(1);
        test_reset();
        test_latency();
        test_round_robin();
        test_timeout();
        test_guard();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
